cpu_sequencer: RTL

- Eight-phase instruction sequencer for the 8-bit RISC core.
- It is the initiator side of the load/enable interface that every `register`, the program counter, memory and bus driver respond to.
- Steps a phase counter through fetch/decode/execute and decodes phase, opcode and the accumulator-zero flag into per-cycle load, read, write and increment strobes.
- Latches a halted state on the HLT instruction.

---
 rtl/cpu_sequencer_if.sv | 30 +++
 rtl/cpu_sequencer.sv | 119 +++++++++++
 2 files changed

// File: rtl/cpu_sequencer_if.sv
// Load/enable interface between the instruction sequencer and the datapath
// blocks (IR, PC, accumulator, memory, bus driver). The sequencer is the
// master: it receives opcode/zero and drives every strobe.
interface cpu_sequencer_if #(
  parameter int opcode_width = 3,
  parameter int phase_width  = 3
);
  logic [opcode_width-1:0] opcode;
  logic                    zero;
  logic                    sel;
  logic                    rd;
  logic                    ld_ir;
  logic                    inc_pc;
  logic                    ld_pc;
  logic                    ld_ac;
  logic                    data_e;
  logic                    wr;
  logic                    halt;
  logic [phase_width-1:0]  phase;

  modport master (
    input  opcode, zero,
    output sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt, phase
  );

  modport slave (
    output opcode, zero,
    input  sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt, phase
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Eight-phase instruction sequencer. A 3-bit phase counter plus a sticky
// halted flag; all strobes are a combinational decode of phase, opcode,
// the accumulator-zero flag and halted. Only widths of 3 are supported.
module cpu_sequencer #(
  parameter int opcode_width = 3,
  parameter int phase_width  = 3
) (
  input  logic              clk,
  input  logic              rst,
  cpu_sequencer_if.master   bus
);

  typedef enum logic [phase_width-1:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  localparam logic [opcode_width-1:0] OP_HLT = 3'd0;
  localparam logic [opcode_width-1:0] OP_SKZ = 3'd1;
  localparam logic [opcode_width-1:0] OP_ADD = 3'd2;
  localparam logic [opcode_width-1:0] OP_AND = 3'd3;
  localparam logic [opcode_width-1:0] OP_XOR = 3'd4;
  localparam logic [opcode_width-1:0] OP_LDA = 3'd5;
  localparam logic [opcode_width-1:0] OP_STO = 3'd6;
  localparam logic [opcode_width-1:0] OP_JMP = 3'd7;

  phase_e phase_q, phase_d;
  logic   halted_q, halted_d;
  logic   aluop;

  // Phase/halted register; reset aborts any instruction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  // Next state: advance every cycle unless halted; HLT freezes at OP_ADDR.
  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if (phase_q == OP_ADDR && bus.opcode == OP_HLT) begin
        halted_d = 1'b1;
      end else begin
        phase_d = phase_e'(phase_q + 1'b1);
      end
    end
  end

  // Strobe decode; halted masks everything except the halt indication.
  always_comb begin
    aluop      = (bus.opcode == OP_ADD) || (bus.opcode == OP_AND) ||
                 (bus.opcode == OP_XOR) || (bus.opcode == OP_LDA);
    bus.sel    = 1'b0;
    bus.rd     = 1'b0;
    bus.ld_ir  = 1'b0;
    bus.inc_pc = 1'b0;
    bus.ld_pc  = 1'b0;
    bus.ld_ac  = 1'b0;
    bus.data_e = 1'b0;
    bus.wr     = 1'b0;
    bus.halt   = 1'b0;
    if (halted_q) begin
      bus.halt = 1'b1;
    end else begin
      case (phase_q)
        INST_ADDR: begin
          bus.sel = 1'b1;
        end
        INST_FETCH: begin
          bus.sel = 1'b1;
          bus.rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          bus.sel   = 1'b1;
          bus.rd    = 1'b1;
          bus.ld_ir = 1'b1;
        end
        OP_ADDR: begin
          bus.inc_pc = 1'b1;
          bus.halt   = (bus.opcode == OP_HLT);
        end
        OP_FETCH: begin
          bus.rd = aluop;
        end
        ALU_OP: begin
          bus.rd     = aluop;
          bus.inc_pc = (bus.opcode == OP_SKZ) && bus.zero;
          bus.ld_pc  = (bus.opcode == OP_JMP);
          bus.data_e = (bus.opcode == OP_STO);
        end
        STORE: begin
          bus.rd     = aluop;
          bus.ld_ac  = aluop;
          bus.ld_pc  = (bus.opcode == OP_JMP);
          bus.inc_pc = (bus.opcode == OP_JMP);
          bus.data_e = (bus.opcode == OP_STO);
          bus.wr     = (bus.opcode == OP_STO);
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.phase = phase_q;

endmodule
